// File: rtl/line_state_mem.sv
// line_state_mem: per-set, per-way valid/dirty store with bulk invalidate and a write-back flush walker
module line_state_mem #(
  parameter int DEPTH  = 512,
  parameter int WAYS   = 2,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [ADDR_W-1:0] RADDR,
  output logic [WAYS-1:0]   VALID_OUT,
  output logic [WAYS-1:0]   DIRTY_OUT,
  input  logic              WREN,
  input  logic [ADDR_W-1:0] WADDR,
  input  logic [WAY_W-1:0]  WWAY,
  input  logic              WVALID,
  input  logic              WDIRTY,
  input  logic              INVALIDATE,
  input  logic              FLUSH_REQ,
  output logic              FLUSH_BUSY,
  output logic              FLUSH_DONE,
  output logic              WB_VALID,
  input  logic              WB_READY,
  output logic [ADDR_W-1:0] WB_ADDR,
  output logic [WAY_W-1:0]  WB_WAY
);
  localparam int N     = DEPTH * WAYS;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, SCAN, WB, DONE} state_t;
  state_t            state, state_nx;
  logic [IDX_W-1:0]  idx, idx_nx;
  logic [WAYS-1:0]   vld [DEPTH];
  logic [WAYS-1:0]   drt [DEPTH];
  logic [ADDR_W-1:0] cur_set;
  logic [WAY_W-1:0]  cur_way;
  logic              cur_dirty, last;
  assign cur_set    = ADDR_W'(idx / WAYS);
  assign cur_way    = WAY_W'(idx % WAYS);
  assign cur_dirty  = vld[cur_set][cur_way] & drt[cur_set][cur_way];
  assign last       = idx == IDX_W'(N - 1);
  assign VALID_OUT  = vld[RADDR];
  assign DIRTY_OUT  = drt[RADDR];
  assign FLUSH_BUSY = state != IDLE;
  assign FLUSH_DONE = state == DONE;
  assign WB_VALID   = state == WB;
  assign WB_ADDR    = cur_set;
  assign WB_WAY     = cur_way;
  // walk sequencing: set-major scan, park in WB until the write-back path accepts
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    unique case (state)
      IDLE: begin
        state_nx = FLUSH_REQ ? SCAN : IDLE;
        idx_nx   = FLUSH_REQ ? '0 : idx;
      end
      SCAN: begin
        state_nx = cur_dirty ? WB : last ? DONE : SCAN;
        idx_nx   = (cur_dirty || last) ? idx : idx + 1'b1;
      end
      WB: begin
        state_nx = !WB_READY ? WB : last ? DONE : SCAN;
        idx_nx   = (WB_READY && !last) ? idx + 1'b1 : idx;
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  // state store and walker registers; reset and invalidate both return everything to empty/idle
  always_ff @(posedge CLK) begin
    if (RST || INVALIDATE) begin
      state <= IDLE;
      idx   <= '0;
      for (int d = 0; d < DEPTH; d++) begin
        vld[d] <= '0;
        drt[d] <= '0;
      end
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
      if (state == WB && WB_READY)
        drt[cur_set][cur_way] <= 1'b0;
      else if (state == IDLE && WREN) begin
        vld[WADDR][WWAY] <= WVALID;
        drt[WADDR][WWAY] <= WVALID & WDIRTY;
      end
    end
  end
endmodule

// File: tb/tb_line_state_mem.sv
// tb_line_state_mem: randomized and directed checks of line_state_mem against a transaction-level model
module tb_line_state_mem;
  localparam int D = 8;
  localparam int W = 2;
  localparam int N = D * W;
  logic       CLK = 1'b0, RST, WREN, WVALID, WDIRTY, INVALIDATE, FLUSH_REQ, WB_READY;
  logic [2:0] RADDR, WADDR, WB_ADDR;
  logic [0:0] WWAY, WB_WAY;
  logic [1:0] VALID_OUT, DIRTY_OUT;
  logic       FLUSH_BUSY, FLUSH_DONE, WB_VALID;
  logic [1:0] mv [D];
  logic [1:0] md [D];
  int n_chk = 0, n_err = 0;
  line_state_mem #(.DEPTH(D), .WAYS(W)) dut (
    .CLK(CLK), .RST(RST), .RADDR(RADDR), .VALID_OUT(VALID_OUT), .DIRTY_OUT(DIRTY_OUT),
    .WREN(WREN), .WADDR(WADDR), .WWAY(WWAY), .WVALID(WVALID), .WDIRTY(WDIRTY),
    .INVALIDATE(INVALIDATE), .FLUSH_REQ(FLUSH_REQ), .FLUSH_BUSY(FLUSH_BUSY),
    .FLUSH_DONE(FLUSH_DONE), .WB_VALID(WB_VALID), .WB_READY(WB_READY),
    .WB_ADDR(WB_ADDR), .WB_WAY(WB_WAY)
  );
  always #5 CLK = ~CLK;
  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic tick;
    @(posedge CLK);
    #1;
  endtask
  task automatic idle_inputs;
    WREN = 0; WVALID = 0; WDIRTY = 0; INVALIDATE = 0; FLUSH_REQ = 0; WB_READY = 0; RST = 0;
  endtask
  task automatic model_clear;
    for (int s = 0; s < D; s++) begin
      mv[s] = '0;
      md[s] = '0;
    end
  endtask
  task automatic rd(input int s);
    RADDR = 3'(s);
    @(negedge CLK);
    check("rd_valid", int'(VALID_OUT), int'(mv[s]));
    check("rd_dirty", int'(DIRTY_OUT), int'(md[s]));
  endtask
  task automatic rd_all;
    for (int s = 0; s < D; s++) rd(s);
  endtask
  task automatic write(input int s, input int w, input bit v, input bit d);
    WREN = 1; WADDR = 3'(s); WWAY = 1'(w); WVALID = v; WDIRTY = d;
    tick;
    WREN = 0;
    mv[s][w] = v;
    md[s][w] = v & d;
  endtask
  task automatic rand_cycle;
    int s;
    s = $urandom_range(0, D - 1);
    RADDR = 3'(s);
    WREN = 1'($urandom_range(0, 1)); WADDR = 3'($urandom_range(0, D - 1));
    WWAY = 1'($urandom_range(0, 1)); WVALID = 1'($urandom_range(0, 1));
    WDIRTY = 1'($urandom_range(0, 1)); WB_READY = 1'($urandom_range(0, 1));
    INVALIDATE = $urandom_range(0, 49) == 0;
    @(negedge CLK);
    check("rnd_valid", int'(VALID_OUT), int'(mv[s]));
    check("rnd_dirty", int'(DIRTY_OUT), int'(md[s]));
    check("rnd_busy", int'(FLUSH_BUSY), 0);
    tick;
    if (INVALIDATE) model_clear();
    else if (WREN) begin
      mv[WADDR][WWAY] = WVALID;
      md[WADDR][WWAY] = WVALID & WDIRTY;
    end
    idle_inputs();
  endtask
  // mode: 0 ready at once, 1 four not-ready cycles per line, 2 random waits
  // abort: 0 none, 1 INVALIDATE on first WB cycle of line number at, 2 RST at busy cycle at
  task automatic flush(input int mode, input int abort, input int at);
    int q[$];
    int c, ext, w, lw, ln, dones;
    bit aborted;
    for (int s = 0; s < D; s++)
      for (int y = 0; y < W; y++)
        if (mv[s][y] && md[s][y]) q.push_back(s * W + y);
    FLUSH_REQ = 1;
    tick;
    FLUSH_REQ = 0;
    c = 0; ext = 0; lw = 0; ln = 0; dones = 0; aborted = 0;
    w = mode == 1 ? 4 : mode == 2 ? $urandom_range(0, 2) : 0;
    while (FLUSH_BUSY && c < 4 * N + 200 && !aborted) begin
      WREN = 1'($urandom_range(0, 1)); WADDR = 3'($urandom_range(0, D - 1));
      WWAY = 1'($urandom_range(0, 1)); WVALID = 1; WDIRTY = 1;
      FLUSH_REQ = 1'($urandom_range(0, 1)); WB_READY = 1'($urandom_range(0, 1));
      if (WB_VALID) begin
        if (q.size() == 0) begin
          check("wb_unexpected", 1, 0);
        end else begin
          if (lw == 0) check("wb_start", c, q[0] + 1 + ext);
          check("wb_addr", int'(WB_ADDR), q[0] / W);
          check("wb_way", int'(WB_WAY), q[0] % W);
          if (abort == 1 && ln == at) begin
            INVALIDATE = 1;
            WB_READY = 0;
            aborted = 1;
          end else if (lw >= w) begin
            WB_READY = 1;
            md[q[0] / W][q[0] % W] = 1'b0;
            ext += 1 + w;
            ln++;
            void'(q.pop_front());
            lw = 0;
            w = mode == 1 ? 4 : mode == 2 ? $urandom_range(0, 2) : 0;
          end else begin
            WB_READY = 0;
            lw++;
          end
        end
      end
      if (abort == 2 && c == at) begin
        RST = 1;
        aborted = 1;
      end
      if (FLUSH_DONE) begin
        dones++;
        check("done_at", c, N + ext);
      end
      c++;
      tick;
      idle_inputs();
    end
    if (aborted) begin
      model_clear();
      check("abort_busy", int'(FLUSH_BUSY), 0);
      check("abort_wbv", int'(WB_VALID), 0);
      check("abort_done", int'(FLUSH_DONE), 0);
      check("abort_dones", dones, 0);
      if (abort == 2) check("rst_wb_addr", int'(WB_ADDR), 0);
    end else begin
      check("walk_ended", int'(FLUSH_BUSY), 0);
      check("busy_cycles", c, N + 1 + ext);
      check("done_pulses", dones, 1);
      check("wb_left", q.size(), 0);
      check("done_after", int'(FLUSH_DONE), 0);
    end
  endtask
  initial begin
    idle_inputs();
    RADDR = 0; WADDR = 0; WWAY = 0;
    model_clear();
    RST = 1;
    tick;
    tick;
    RST = 0;
    check("rst_busy", int'(FLUSH_BUSY), 0);
    check("rst_done", int'(FLUSH_DONE), 0);
    check("rst_wbv", int'(WB_VALID), 0);
    check("rst_wb_addr", int'(WB_ADDR), 0);
    check("rst_wb_way", int'(WB_WAY), 0);
    rd_all();
    write(3, 1, 1, 0); rd(3);
    check("t2_v10", int'(VALID_OUT), 2);
    write(3, 1, 1, 1); rd(3);
    check("t2_d10", int'(DIRTY_OUT), 2);
    write(3, 1, 0, 1); rd(3);
    check("t2_d00", int'(DIRTY_OUT), 0);
    for (int s = 0; s < D; s++)
      for (int y = 0; y < W; y++) write(s, y, 1, 0);
    flush(0, 0, 0);
    rd_all();
    write(0, 1, 1, 1);
    write(5, 0, 1, 1);
    flush(1, 0, 0);
    rd_all();
    write(0, 1, 1, 1);
    write(5, 0, 1, 1);
    flush(1, 1, 1);
    rd_all();
    write(2, 1, 1, 1);
    WREN = 1; WADDR = 3'd2; WWAY = 1'b0; WVALID = 1; WDIRTY = 1; INVALIDATE = 1;
    tick;
    idle_inputs();
    model_clear();
    rd(2);
    write(1, 0, 1, 1);
    write(6, 1, 1, 1);
    flush(2, 2, 5);
    rd_all();
    repeat (300) rand_cycle();
    repeat (4) begin
      repeat (12) write($urandom_range(0, D - 1), $urandom_range(0, 1), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      flush(2, 0, 0);
      rd_all();
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
